kamus_csr: RTL

Machine-mode CSR register file: the write and update side of the CSR space that the execute stage reads.
- Applies CSRRW/CSRRS/CSRRC writes; supplies pre-write read data back to the pipeline.
- Maintains the 64-bit cycle/instret counters and the timer compare register.
- Performs trap-entry and mret state updates; raises the interrupt-pending request to the core.
- Sits beside the EX stage; its writeback commits in the same cycle the CSR instruction retires.

---
 rtl/kamus_csr.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/kamus_csr.sv
// kamus_csr: machine-mode CSR register file.
// Holds the write/update side of the M-mode CSR space: CSRRW/CSRRS/CSRRC
// commits, the 64-bit cycle/instret counters, the timer compare register,
// trap-entry/mret bookkeeping and the registered interrupt request.
// Read data is combinational and always reflects the pre-write value.
module kamus_csr #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [11:0] csr_addr_i,
  input  logic [1:0]  csr_op_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        instret_i,
  input  logic        trap_i,
  input  logic [31:0] trap_pc_i,
  input  logic [4:0]  trap_cause_i,
  input  logic [31:0] trap_tval_i,
  input  logic        mret_i,
  input  logic        irq_ext_i,
  input  logic        irq_sw_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        irq_pending_o
);

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MBADADDR  = 12'h343;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MTIMECMP  = 12'h7C0;
  localparam logic [11:0] ADDR_MTIMECMPH = 12'h7C1;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_TIME      = 12'hC01;
  localparam logic [11:0] ADDR_TIMEH     = 12'hC81;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
  localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  // Architectural state
  logic        mstatus_mie_q,  mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic        mie_meie_q,     mie_meie_d;
  logic        mie_mtie_q,     mie_mtie_d;
  logic        mie_msie_q,     mie_msie_d;
  logic [31:0] mtvec_q,        mtvec_d;
  logic [31:0] mepc_q,         mepc_d;
  logic [31:0] mscratch_q,     mscratch_d;
  logic [31:0] mbadaddr_q,     mbadaddr_d;
  logic [4:0]  mcause_q,       mcause_d;
  logic [63:0] cycle_q,        cycle_d;
  logic [63:0] instret_q,      instret_d;
  logic [63:0] timecmp_q,      timecmp_d;

  // Interrupt sampling: external/software levels, timer compare, SW-set msip
  logic        meip_q,         meip_d;
  logic        mtip_q,         mtip_d;
  logic        irq_sw_q,       irq_sw_d;
  logic        msip_sw_q,      msip_sw_d;
  logic        irq_pending_q,  irq_pending_d;

  csr_op_e     op;
  logic        msip_eff;
  logic [31:0] mstatus_rd;
  logic [31:0] mip_rd;
  logic [31:0] mie_rd;
  logic [31:0] mcause_rd;
  logic [31:0] read_val;
  logic        writable;
  logic [31:0] wval;
  logic        csr_we;

  assign op       = csr_op_e'(csr_op_i);
  assign msip_eff = irq_sw_q | msip_sw_q;

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
  assign mip_rd     = {20'b0, meip_q, 3'b0, mtip_q, 3'b0, msip_eff, 3'b0};
  assign mie_rd     = {20'b0, mie_meie_q, 3'b0, mie_mtie_q, 3'b0, mie_msie_q, 3'b0};
  assign mcause_rd  = {mcause_q[4], 27'b0, mcause_q[3:0]};

  // Address decode: pre-write read value and whether the address accepts writes
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    read_val = 32'h0;
    writable = 1'b0;
    unique case (csr_addr_i)
      ADDR_MSTATUS:   begin read_val = mstatus_rd;        writable = 1'b1; end
      ADDR_MISA:      begin read_val = MISA_VALUE;                          end
      ADDR_MIE:       begin read_val = mie_rd;            writable = 1'b1; end
      ADDR_MTVEC:     begin read_val = mtvec_q;           writable = 1'b1; end
      ADDR_MSCRATCH:  begin read_val = mscratch_q;        writable = 1'b1; end
      ADDR_MEPC:      begin read_val = mepc_q;            writable = 1'b1; end
      ADDR_MCAUSE:    begin read_val = mcause_rd;         writable = 1'b1; end
      ADDR_MBADADDR:  begin read_val = mbadaddr_q;        writable = 1'b1; end
      ADDR_MIP:       begin read_val = mip_rd;            writable = 1'b1; end
      ADDR_MCYCLE:    begin read_val = cycle_q[31:0];     writable = 1'b1; end
      ADDR_MCYCLEH:   begin read_val = cycle_q[63:32];    writable = 1'b1; end
      ADDR_MINSTRET:  begin read_val = instret_q[31:0];   writable = 1'b1; end
      ADDR_MINSTRETH: begin read_val = instret_q[63:32];  writable = 1'b1; end
      ADDR_MTIMECMP:  begin read_val = timecmp_q[31:0];   writable = 1'b1; end
      ADDR_MTIMECMPH: begin read_val = timecmp_q[63:32];  writable = 1'b1; end
      ADDR_CYCLE,
      ADDR_TIME:      read_val = cycle_q[31:0];
      ADDR_CYCLEH,
      ADDR_TIMEH:     read_val = cycle_q[63:32];
      ADDR_INSTRET:   read_val = instret_q[31:0];
      ADDR_INSTRETH:  read_val = instret_q[63:32];
      ADDR_MVENDORID,
      ADDR_MARCHID,
      ADDR_MIMPID,
      ADDR_MHARTID:   read_val = 32'h0;
      default:        read_val = 32'h0;
    endcase
  end

  // Read-modify-write value for the addressed CSR
  always_comb begin
    wval = csr_wdata_i;
    unique case (op)
      CSR_RW:   wval = csr_wdata_i;
      CSR_RS:   wval = read_val | csr_wdata_i;
      CSR_RC:   wval = read_val & ~csr_wdata_i;
      default:  wval = csr_wdata_i;
    endcase
  end

  assign csr_rdata_o   = read_val;
  assign csr_illegal_o = (op != CSR_NONE) && !writable;
  // Trap and mret own this cycle; a coinciding CSR write is dropped.
  assign csr_we        = (op != CSR_NONE) && writable && !trap_i && !mret_i;

  // Next-state: counters, interrupt sampling, trap/mret, then CSR writes
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_meie_d     = mie_meie_q;
    mie_mtie_d     = mie_mtie_q;
    mie_msie_d     = mie_msie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mscratch_d     = mscratch_q;
    mbadaddr_d     = mbadaddr_q;
    mcause_d       = mcause_q;
    timecmp_d      = timecmp_q;
    msip_sw_d      = msip_sw_q;
    cycle_d        = cycle_q + 64'd1;
    instret_d      = instret_q + 64'(instret_i);
    meip_d         = irq_ext_i;
    irq_sw_d       = irq_sw_i;
    mtip_d         = (cycle_q >= timecmp_q);
    irq_pending_d  = mstatus_mie_q && ((mip_rd & mie_rd) != 32'h0);

    if (trap_i) begin
      mepc_d         = trap_pc_i & 32'hFFFF_FFFC;
      mcause_d       = trap_cause_i;
      mbadaddr_d     = trap_tval_i;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_i) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end

    // A write to one counter half freezes the other half for that cycle.
    if (csr_we) begin
      unique case (csr_addr_i)
        ADDR_MSTATUS: begin
          mstatus_mie_d  = wval[3];
          mstatus_mpie_d = wval[7];
        end
        ADDR_MIE: begin
          mie_meie_d = wval[11];
          mie_mtie_d = wval[7];
          mie_msie_d = wval[3];
        end
        ADDR_MTVEC:     mtvec_d    = {wval[31:2], 2'b00};
        ADDR_MSCRATCH:  mscratch_d = wval;
        ADDR_MEPC:      mepc_d     = {wval[31:2], 2'b00};
        ADDR_MCAUSE:    mcause_d   = {wval[31], wval[3:0]};
        ADDR_MBADADDR:  mbadaddr_d = wval;
        ADDR_MIP:       msip_sw_d  = wval[3];
        ADDR_MCYCLE:    cycle_d    = {cycle_q[63:32], wval};
        ADDR_MCYCLEH:   cycle_d    = {wval, cycle_q[31:0]};
        ADDR_MINSTRET:  instret_d  = {instret_q[63:32], wval};
        ADDR_MINSTRETH: instret_d  = {wval, instret_q[31:0]};
        ADDR_MTIMECMP:  timecmp_d  = {timecmp_q[63:32], wval};
        ADDR_MTIMECMPH: timecmp_d  = {wval, timecmp_q[31:0]};
        default: ;
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before the edge, independent of statement order.
    if (!rst_ni) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_meie_q     <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mie_msie_q     <= 1'b0;
      mtvec_q        <= MTVEC_RESET & 32'hFFFF_FFFC;
      mepc_q         <= 32'h0;
      mscratch_q     <= 32'h0;
      mbadaddr_q     <= 32'h0;
      mcause_q       <= 5'h0;
      cycle_q        <= 64'h0;
      instret_q      <= 64'h0;
      timecmp_q      <= 64'hFFFF_FFFF_FFFF_FFFF;
      meip_q         <= 1'b0;
      mtip_q         <= 1'b0;
      irq_sw_q       <= 1'b0;
      msip_sw_q      <= 1'b0;
      irq_pending_q  <= 1'b0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_meie_q     <= mie_meie_d;
      mie_mtie_q     <= mie_mtie_d;
      mie_msie_q     <= mie_msie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mscratch_q     <= mscratch_d;
      mbadaddr_q     <= mbadaddr_d;
      mcause_q       <= mcause_d;
      cycle_q        <= cycle_d;
      instret_q      <= instret_d;
      timecmp_q      <= timecmp_d;
      meip_q         <= meip_d;
      mtip_q         <= mtip_d;
      irq_sw_q       <= irq_sw_d;
      msip_sw_q      <= msip_sw_d;
      irq_pending_q  <= irq_pending_d;
    end
  end

  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;
  assign irq_pending_o = irq_pending_q;

endmodule
